// File: rtl/sub8_reg_unit.sv
// sub8_reg_unit: registered WIDTH-bit subtractor (a - b) with optional
// unsigned/signed saturation and borrow/overflow/zero/negative status.
// One register stage: a sample taken with in_valid high is presented with
// out_valid high one cycle later. With in_valid low, result and flags hold.
module sub8_reg_unit #(
    parameter int WIDTH  = 8,
    parameter bit SAT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sat_mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] SMIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SMAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

    // Final result selection from the raw difference and its status.
    // Saturation is only honoured when the saturation hardware is built.
    function automatic logic [WIDTH-1:0] sat_select(
        input logic [WIDTH-1:0] raw,
        input logic             brw,
        input logic             ovf,
        input logic             a_msb,
        input logic [1:0]       mode
    );
        logic [WIDTH-1:0] res;
        res = raw;
        if (SAT_EN) begin
            case (mode)
                2'b01: begin
                    if (brw) begin
                        res = ZERO_VAL;
                    end else begin
                        res = raw;
                    end
                end
                2'b10: begin
                    // Signed overflow can only push past the limit on the side
                    // of the minuend's sign: negative a underflows, positive a overflows.
                    if (ovf) begin
                        res = a_msb ? SMIN_VAL : SMAX_VAL;
                    end else begin
                        res = raw;
                    end
                end
                default: res = raw;
            endcase
        end else begin
            res = raw;
        end
        return res;
    endfunction

    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] raw_s;
    logic             borrow_s;
    logic             overflow_s;
    logic [WIDTH-1:0] result_s;

    logic             valid_q,    valid_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             borrow_q,   borrow_d;
    logic             overflow_q, overflow_d;
    logic             zero_q,     zero_d;
    logic             negative_q, negative_d;

    // Subtraction with a widened difference so the top bit is the unsigned borrow.
    always_comb begin
        diff_s     = {1'b0, a} - {1'b0, b};
        raw_s      = diff_s[WIDTH-1:0];
        borrow_s   = diff_s[WIDTH];
        overflow_s = (a[WIDTH-1] != b[WIDTH-1]) && (raw_s[WIDTH-1] != a[WIDTH-1]);
        result_s   = sat_select(raw_s, borrow_s, overflow_s, a[WIDTH-1], sat_mode);
    end

    // Next-state: capture a new sample when in_valid, otherwise hold result and flags.
    always_comb begin
        valid_d    = in_valid;
        result_d   = result_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        if (in_valid) begin
            result_d   = result_s;
            borrow_d   = borrow_s;
            overflow_d = overflow_s;
            zero_d     = (result_s == ZERO_VAL);
            negative_d = result_s[WIDTH-1];
        end else begin
            result_d   = result_q;
            borrow_d   = borrow_q;
            overflow_d = overflow_q;
            zero_d     = zero_q;
            negative_d = negative_q;
        end
    end

    // Output register stage; asynchronous reset clears everything, dropping any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            result_q   <= ZERO_VAL;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            result_q   <= result_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign borrow    = borrow_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;

endmodule

// File: tb/tb_sub8_reg_unit.sv
// Scoreboard bench for sub8_reg_unit: two instances (saturation built / not
// built) share the same stimulus; expected responses come from an integer
// arithmetic reference model and are checked by an independent monitor.
module tb_sub8_reg_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] sat_mode;

    logic       ov1, bo1, of1, ze1, ne1;
    logic [7:0] re1;
    logic       ov0, bo0, of0, ze0, ne0;
    logic [7:0] re0;

    int ntests;
    int nfail;
    int cyc;

    typedef struct {
        int         due;
        logic [7:0] r1;
        logic       z1;
        logic       n1;
        logic [7:0] r0;
        logic       z0;
        logic       n0;
        logic       brw;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t hold_e;

    sub8_reg_unit #(.WIDTH(8), .SAT_EN(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .sat_mode(sat_mode),
        .out_valid(ov1), .result(re1), .borrow(bo1), .overflow(of1), .zero(ze1), .negative(ne1)
    );

    sub8_reg_unit #(.WIDTH(8), .SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .sat_mode(sat_mode),
        .out_valid(ov0), .result(re0), .borrow(bo0), .overflow(of0), .zero(ze0), .negative(ne0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int ua, input int ub, input int mode);
        exp_t e;
        int sa, sb, sd, raw, r1;
        sa  = (ua >= 128) ? ua - 256 : ua;
        sb  = (ub >= 128) ? ub - 256 : ub;
        sd  = sa - sb;
        raw = (ua - ub + 256) % 256;
        e.brw = (ua < ub);
        e.ovf = (sd > 127) || (sd < -128);
        r1 = raw;
        if (mode == 1 && ua < ub) r1 = 0;
        if (mode == 2 && sd > 127) r1 = 127;
        if (mode == 2 && sd < -128) r1 = 128;
        e.r1  = 8'(r1);
        e.z1  = (r1 == 0);
        e.n1  = (r1 >= 128);
        e.r0  = 8'(raw);
        e.z0  = (raw == 0);
        e.n0  = (raw >= 128);
        e.due = 0;
        return e;
    endfunction

    // One cycle of stimulus; valid samples push their expected response.
    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y, input logic [1:0] m);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        a        = x;
        b        = y;
        sat_mode = m;
        if (v) begin
            e     = model(int'(x), int'(y), int'(m));
            e.due = cyc + 1;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle();
        drive(1'b0, 8'($urandom), 8'($urandom), 2'($urandom));
    endtask

    task automatic check_all_zero(input string nm);
        ntests++;
        if ({ov1, re1, bo1, of1, ze1, ne1, ov0, re0, bo0, of0, ze0, ne0} != 26'd0) begin
            nfail++;
            $display("FAIL %s: got %h %h %b%b%b%b / %h %h %b%b%b%b, want all zero", nm,
                     ov1, re1, bo1, of1, ze1, ne1, ov0, re0, bo0, of0, ze0, ne0);
        end
    endtask

    // Monitor: pop and compare when a result is due, otherwise require idle and held outputs.
    always @(negedge clk) begin
        exp_t e;
        logic [23:0] got, want;
        if (!rst_n) begin
            sb_q.delete();
            hold_e = '{0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        end else begin
            got = {re1, bo1, of1, ze1, ne1, re0, bo0, of0, ze0, ne0};
            ntests++;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                want = {e.r1, e.brw, e.ovf, e.z1, e.n1, e.r0, e.brw, e.ovf, e.z0, e.n0};
                if (!ov1 || !ov0 || got !== want) begin
                    nfail++;
                    $display("FAIL result cyc=%0d: got valid=%b%b data=%h, want valid=11 data=%h",
                             cyc, ov1, ov0, got, want);
                end
                hold_e = e;
            end else begin
                e = hold_e;
                want = {e.r1, e.brw, e.ovf, e.z1, e.n1, e.r0, e.brw, e.ovf, e.z0, e.n0};
                if (ov1 || ov0 || got !== want) begin
                    nfail++;
                    $display("FAIL hold cyc=%0d: got valid=%b%b data=%h, want valid=00 data=%h",
                             cyc, ov1, ov0, got, want);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ntests   = 0;
        nfail    = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 8'd0;
        b        = 8'd0;
        sat_mode = 2'b00;
        #1;
        check_all_zero("reset_state");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Directed wrap sequence, back-to-back.
        drive(1'b1, 8'd3,   8'd1,   2'b00);
        drive(1'b1, 8'd4,   8'd3,   2'b00);
        drive(1'b1, 8'd6,   8'd3,   2'b00);
        drive(1'b1, 8'd76,  8'd21,  2'b00);
        drive(1'b1, 8'd129, 8'd129, 2'b00);
        drive(1'b1, 8'd97,  8'd33,  2'b00);
        drive(1'b1, 8'd248, 8'd2,   2'b00);
        // Underflow, signed overflow, negative saturation, a==b in every mode.
        drive(1'b1, 8'd1,   8'd3,   2'b00);
        drive(1'b1, 8'd1,   8'd3,   2'b01);
        drive(1'b1, 8'h7F,  8'hFF,  2'b00);
        drive(1'b1, 8'h7F,  8'hFF,  2'b10);
        drive(1'b1, 8'h80,  8'h01,  2'b10);
        drive(1'b1, 8'h80,  8'h01,  2'b00);
        drive(1'b1, 8'h80,  8'h01,  2'b11);
        drive(1'b1, 8'h55,  8'h55,  2'b01);
        drive(1'b1, 8'h80,  8'h80,  2'b10);
        drive(1'b1, 8'hFF,  8'hFF,  2'b11);
        // Single pulse then idle: result must hold.
        idle();
        drive(1'b1, 8'd10,  8'd200, 2'b01);
        repeat (4) idle();

        // Randomized mix of valid and idle cycles across all modes.
        for (int i = 0; i < 400; i++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        // Reset while out_valid is high.
        drive(1'b1, 8'd200, 8'd1, 2'b00);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        ntests++;
        if (!ov1 || !ov0) begin
            nfail++;
            $display("FAIL pre_reset_valid: got %b%b, want 11", ov1, ov0);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) idle();
        check_all_zero("after_release");
        drive(1'b1, 8'd0, 8'd1, 2'b10);
        repeat (3) idle();

        ntests++;
        if (sb_q.size() != 0) begin
            nfail++;
            $display("FAIL drain: %0d results outstanding, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
